// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width_src control codes,
// controller state encoding and the alignment legality check.
package lsu_pkg;

  localparam logic [2:0] WIDTH_32  = 3'd0;
  localparam logic [2:0] WIDTH_16S = 3'd1;
  localparam logic [2:0] WIDTH_16U = 3'd2;
  localparam logic [2:0] WIDTH_8S  = 3'd3;
  localparam logic [2:0] WIDTH_8U  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // True when the access is misaligned for its size or the code is unknown.
  function automatic logic access_bad(input logic [2:0] width, input logic [1:0] lo);
    case (width)
      WIDTH_32:            return (lo != 2'b00);
      WIDTH_16S, WIDTH_16U: return lo[0];
      WIDTH_8S, WIDTH_8U:   return 1'b0;
      default:             return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data lane select and sign/zero extension, purely combinational.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [1:0]       lane_i,
  input  logic [2:0]       width_i,
  output logic [WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
    data_o   = '0;
    case (width_i)
      WIDTH_32:  data_o = word_i;
      WIDTH_16S: data_o = {{(WIDTH-16){half_sel[15]}}, half_sel};
      WIDTH_16U: data_o = {{(WIDTH-16){1'b0}}, half_sel};
      WIDTH_8S:  data_o = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      WIDTH_8U:  data_o = {{(WIDTH-8){1'b0}}, byte_sel};
      default:   data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one pipeline request at a time, issues a
// single word-aligned memory access with byte enables, returns extended data.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_width_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic             mem_rvalid_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output lsu_state_e       state_o
);

  // Handshakes: a request transfers on a rising edge with req_valid_i && req_ready_o;
  // mem_req_o and its payload stay fixed until a rising edge with mem_gnt_i;
  // mem_rvalid_i completes the access only while in WAIT and is otherwise ignored.

  lsu_state_e       state_q, state_d;
  logic             we_q, err_q;
  logic [2:0]       width_q;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q, load_data;
  logic [3:0]       be_c;
  logic [WIDTH-1:0] wdata_c;
  logic             accept, in_req, in_resp;

  assign accept  = (state_q == IDLE) && req_valid_i;
  assign in_req  = (state_q == REQ);
  assign in_resp = (state_q == RESP);

  lsu_load_ext #(.WIDTH(WIDTH)) u_load_ext (
    .word_i  (mem_rdata_i),
    .lane_i  (addr_q[1:0]),
    .width_i (width_q),
    .data_o  (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      width_q <= WIDTH_32;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        width_q <= req_width_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        err_q   <= access_bad(req_width_i, req_addr_i[1:0]);
        rdata_q <= '0;
      end else if ((state_q == WAIT) && mem_rvalid_i) begin
        rdata_q <= we_q ? '0 : load_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i)
              state_d = access_bad(req_width_i, req_addr_i[1:0]) ? RESP : REQ;
      REQ:  if (mem_gnt_i) state_d = WAIT;
      WAIT: if (mem_rvalid_i) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane enables and replicated store data derived from the captured request.
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = wdata_q;
    case (width_q)
      WIDTH_32: be_c = 4'b1111;
      WIDTH_16S, WIDTH_16U: begin
        be_c    = 4'b0011 << {addr_q[1], 1'b0};
        wdata_c = WIDTH'({2{wdata_q[15:0]}});
      end
      WIDTH_8S, WIDTH_8U: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wdata_c = WIDTH'({4{wdata_q[7:0]}});
      end
      default: be_c = 4'b0000;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req & we_q;
  assign mem_be_o    = in_req ? be_c : 4'b0000;
  assign mem_addr_o  = in_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata_o = in_req ? wdata_c : '0;
  assign rsp_valid_o = in_resp;
  assign rsp_err_o   = in_resp & err_q;
  assign rsp_rdata_o = in_resp ? rdata_q : '0;
  assign state_o     = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stores, loads, errors, grant stall, reset abort.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [2:0]  req_width_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  lsu_state_e  state_o;

  int total = 0;
  int bad   = 0;
  time last_rsp_t = 0;
  time prev_rsp_t = 0;

  always #5 clk_i = ~clk_i;

  lsu_ctrl #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_width_i(req_width_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic we, input logic [2:0] w, input logic [31:0] addr,
                        input logic [31:0] wdata);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_width_i = w;
    req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_wdata_i = 32'h0; req_addr_i = 32'h0;
  endtask

  // Full transaction with grant in REQ and rvalid in the following cycle.
  task automatic run_txn(input string tag, input logic we, input logic [2:0] w,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_maddr, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata);
    accept(we, w, addr, wdata);
    @(negedge clk_i);
    chk({tag, ".req"}, mem_req_o, 1);
    chk({tag, ".we"}, mem_we_o, we);
    chk({tag, ".be"}, mem_be_o, exp_be);
    chk({tag, ".maddr"}, mem_addr_o, exp_maddr);
    if (we) chk({tag, ".wdata"}, mem_wdata_o, exp_wdata);
    chk({tag, ".ready"}, req_ready_o, 0);
    mem_gnt_i = 1'b1;
    @(posedge clk_i); #1 mem_gnt_i = 1'b0;
    @(negedge clk_i);
    chk({tag, ".wait_rsp"}, rsp_valid_o, 0);
    chk({tag, ".wait_req"}, mem_req_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
    @(posedge clk_i); #1 mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk_i);
    chk({tag, ".rsp_valid"}, rsp_valid_o, 1);
    chk({tag, ".rsp_err"}, rsp_err_o, 0);
    chk({tag, ".rdata"}, rsp_rdata_o, exp_rdata);
    prev_rsp_t = last_rsp_t;
    last_rsp_t = $time;
  endtask

  task automatic run_err(input string tag, input logic we, input logic [2:0] w,
                         input logic [31:0] addr);
    accept(we, w, addr, 32'hFFFF_FFFF);
    @(negedge clk_i);
    chk({tag, ".rsp_valid"}, rsp_valid_o, 1);
    chk({tag, ".rsp_err"}, rsp_err_o, 1);
    chk({tag, ".rdata"}, rsp_rdata_o, 0);
    chk({tag, ".no_req"}, mem_req_o, 0);
    @(negedge clk_i);
    chk({tag, ".done"}, rsp_valid_o, 0);
    chk({tag, ".no_req2"}, mem_req_o, 0);
    chk({tag, ".ready"}, req_ready_o, 1);
  endtask

  initial begin
    rst_n_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_width_i = WIDTH_32;
    req_addr_i = 32'h0; req_wdata_i = 32'h0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #12;
    chk("rst.ready", req_ready_o, 1);
    chk("rst.req", mem_req_o, 0);
    chk("rst.be", mem_be_o, 0);
    chk("rst.rsp", rsp_valid_o, 0);
    chk("rst.state", 32'(state_o), 32'(IDLE));
    @(negedge clk_i); rst_n_i = 1'b1;

    // Stray rvalid in IDLE must not produce a response.
    @(negedge clk_i); mem_rvalid_i = 1'b1;
    @(negedge clk_i); mem_rvalid_i = 1'b0;
    chk("idle_rvalid.rsp", rsp_valid_o, 0);
    chk("idle_rvalid.ready", req_ready_o, 1);

    run_txn("st8", 1, WIDTH_8S, 32'h103, 32'hAB, 32'h0, 4'b1000, 32'h100, 32'hABABABAB, 32'h0);
    run_txn("st16", 1, WIDTH_16U, 32'h2, 32'h1234_5678, 32'h0, 4'b1100, 32'h0, 32'h56785678, 32'h0);
    run_txn("st32", 1, WIDTH_32, 32'h10, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'h10, 32'hCAFEF00D, 32'h0);
    run_txn("ld16s", 0, WIDTH_16S, 32'h42, 32'h0, 32'h8001_1234, 4'b1100, 32'h40, 32'h0, 32'hFFFF8001);
    run_txn("ld16u", 0, WIDTH_16U, 32'h42, 32'h0, 32'h8001_1234, 4'b1100, 32'h40, 32'h0, 32'h00008001);
    // Back-to-back: accepted the cycle after the previous response.
    chk("b2b.period", 32'(last_rsp_t - prev_rsp_t), 32'd40);
    run_txn("ld8u", 0, WIDTH_8U, 32'h1, 32'h0, 32'h1122_8344, 4'b0010, 32'h0, 32'h0, 32'h00000083);
    chk("b2b.period2", 32'(last_rsp_t - prev_rsp_t), 32'd40);
    run_txn("ld8s", 0, WIDTH_8S, 32'h1, 32'h0, 32'h1122_8344, 4'b0010, 32'h0, 32'h0, 32'hFFFFFF83);
    run_txn("ld8s_pos", 0, WIDTH_8S, 32'h203, 32'h0, 32'h7F00_0000, 4'b1000, 32'h200, 32'h0, 32'h0000007F);
    run_txn("ld32", 0, WIDTH_32, 32'h8, 32'h0, 32'hDEAD_BEEF, 4'b1111, 32'h8, 32'h0, 32'hDEADBEEF);

    run_err("err32", 0, WIDTH_32, 32'h06);
    run_err("err16", 0, WIDTH_16S, 32'h11);
    run_err("errcode", 1, 3'd5, 32'h20);

    // Grant withheld for 5 cycles; a stray rvalid in REQ must be ignored.
    accept(1, WIDTH_16S, 32'h22, 32'h0000_BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      mem_rvalid_i = (i == 2);
      chk("stall.req", mem_req_o, 1);
      chk("stall.addr", mem_addr_o, 32'h20);
      chk("stall.be", mem_be_o, 4'b1100);
      chk("stall.wdata", mem_wdata_o, 32'hBEEFBEEF);
      chk("stall.ready", req_ready_o, 0);
      chk("stall.rsp", rsp_valid_o, 0);
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    chk("stall.req_hold", mem_req_o, 1);
    mem_gnt_i = 1'b1;
    @(posedge clk_i); #1 mem_gnt_i = 1'b0;
    @(negedge clk_i); mem_rvalid_i = 1'b1;
    @(posedge clk_i); #1 mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("stall.rsp_valid", rsp_valid_o, 1);
    chk("stall.rdata", rsp_rdata_o, 0);

    // Reset while in REQ drops the memory request at once.
    accept(0, WIDTH_32, 32'h44, 32'h0);
    @(negedge clk_i);
    chk("rstreq.req_before", mem_req_o, 1);
    rst_n_i = 1'b0; #1;
    chk("rstreq.req", mem_req_o, 0);
    chk("rstreq.be", mem_be_o, 0);
    chk("rstreq.addr", mem_addr_o, 0);
    @(negedge clk_i); rst_n_i = 1'b1;

    // Reset while in WAIT abandons the load with no response.
    accept(0, WIDTH_32, 32'h48, 32'h0);
    @(negedge clk_i); mem_gnt_i = 1'b1;
    @(posedge clk_i); #1 mem_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("rstwait.state", 32'(state_o), 32'(WAIT));
    rst_n_i = 1'b0; #1;
    chk("rstwait.req", mem_req_o, 0);
    chk("rstwait.rsp", rsp_valid_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    @(negedge clk_i); rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      chk("rstwait.no_rsp", rsp_valid_o, 0);
      chk("rstwait.ready", req_ready_o, 1);
    end
    run_txn("post_rst", 0, WIDTH_16U, 32'h4E, 32'h0, 32'hA5A5_0000, 4'b1100, 32'h4C, 32'h0, 32'h0000A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
